// File: rtl/ram_drain_reader_pkg.sv
// Shared types and helpers for the RAM drain reader.
// RAM_DRAIN_READER_WRAP_EN selects circular addressing in next_addr.
package ram_drain_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Width of a counter that must hold 0..fifo_depth (credits, FIFO occupancy).
    function automatic int cred_w(input int fifo_depth);
        return $clog2(fifo_depth + 1);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] depth);
`ifdef RAM_DRAIN_READER_WRAP_EN
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
`else
        // Legal windows never step past depth-1, so holding there is never observed.
        return (addr >= depth) ? addr : addr + 32'd1;
`endif
    endfunction

endpackage

// File: rtl/ram_drain_skid_fifo.sv
// Register-based first-word-fall-through FIFO; head visible the cycle after push.
// Push and pop together keep occupancy; push while full is accepted only with a pop.
module ram_drain_skid_fifo
    import ram_drain_reader_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 3,
    localparam int CNT_W = cred_w(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= bump(wr_q);
            end
            if (do_pop) begin
                rd_q <= bump(rd_q);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ram_drain_reader.sv
// Drains a RAM window over port B to a valid/ready stream; first word LATENCY+2 cycles after start.
// Issue is credit-gated so backpressure never loses a RAM return; RAM_DRAIN_READER_WRAP_EN enables wrap.
module ram_drain_reader
    import ram_drain_reader_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = LATENCY + 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [WIDTH-1:0]  ram_data,
    output logic              ram_clken,
    input  logic [WIDTH-1:0]  ram_q,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CRED_W = cred_w(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] lst_q, lst_d;
    logic [CRED_W-1:0] infl_q, infl_d;

    logic              issue;
    logic              ret;
    logic              credit_ok;
    logic              window_bad;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CRED_W-1:0] fifo_cnt;
    logic [WIDTH:0]    fifo_wdat;
    logic [WIDTH:0]    fifo_rdat;

`ifdef RAM_DRAIN_READER_WRAP_EN
    assign window_bad = (num_words > CNT_W'(DEPTH)) || ({1'b0, base_addr} >= CNT_W'(DEPTH));
`else
    logic [ADDR_W+1:0] win_end;
    assign win_end    = {2'b00, base_addr} + {1'b0, num_words};
    assign window_bad = (win_end > (ADDR_W + 2)'(DEPTH));
`endif

    // Returns already in the pipe plus words parked in the FIFO must always fit the FIFO.
    assign credit_ok = !fifo_full &&
                       (({1'b0, infl_q} + {1'b0, fifo_cnt}) < (CRED_W + 1)'(FIFO_DEPTH));
    assign ret       = vld_q[LATENCY-1];
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_wdat = {lst_q[LATENCY-1], ram_q};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        state_d = FIN;
                        err_d   = 1'b0;
                    end else if (window_bad) begin
                        state_d = FIN;
                        err_d   = 1'b1;
                    end else begin
                        addr_d  = base_addr;
                        rem_d   = num_words;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = ADDR_W'(next_addr(32'(addr_q), 32'(DEPTH)));
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the last word is consumed so done follows it by one cycle.
                if (infl_q == '0 &&
                    (fifo_empty || (fifo_cnt == CRED_W'(1) && fifo_pop))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_d    = vld_q;
        lst_d    = lst_q;
        vld_d[0] = issue;
        lst_d[0] = issue && (rem_q == CNT_W'(1));
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
        infl_d = infl_q + CRED_W'(issue) - CRED_W'(ret);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            lst_q   <= '0;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
            infl_q  <= infl_d;
        end
    end

    ram_drain_skid_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (ret),
        .wdata  (fifo_wdat),
        .pop    (fifo_pop),
        .rdata  (fifo_rdat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign err       = err_q;
    assign ram_addr  = addr_q;
    assign ram_wren  = 1'b0;
    assign ram_data  = '0;
    assign ram_clken = 1'b1;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdat[WIDTH-1:0];
    assign out_last  = fifo_rdat[WIDTH] && !fifo_empty;

endmodule

// File: tb/tb_ram_drain_reader.sv
// Scoreboard bench: instance A (LATENCY=1) and instance B (LATENCY=3) share clock and reset.
// Expected words are queued at start and popped as the stream hands them over.
module tb_ram_drain_reader;

    localparam int W     = 32;
    localparam int AW    = 8;
    localparam int DEP   = 256;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int FD_B  = LAT_B + 2;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 resetn;
    logic [1:0]           start_v;
    logic [1:0][AW-1:0]   base_v;
    logic [1:0][AW:0]     num_v;
    logic [1:0]           ready_v;
    logic [1:0]           busy_v, done_v, err_v, wren_v, clken_v, valid_v, last_v;
    logic [1:0][AW-1:0]   addr_v;
    logic [1:0][W-1:0]    rdat_v, dat_v;
    logic [W-1:0]         q_a, qb0, qb1, qb2;
    logic [W-1:0]         mem [DEP];

    ram_drain_reader #(.WIDTH(W), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .resetn(resetn), .start(start_v[0]), .base_addr(base_v[0]), .num_words(num_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .ram_addr(addr_v[0]),
        .ram_wren(wren_v[0]), .ram_data(rdat_v[0]), .ram_clken(clken_v[0]), .ram_q(q_a),
        .out_data(dat_v[0]), .out_valid(valid_v[0]), .out_ready(ready_v[0]), .out_last(last_v[0])
    );

    ram_drain_reader #(.WIDTH(W), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .resetn(resetn), .start(start_v[1]), .base_addr(base_v[1]), .num_words(num_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .ram_addr(addr_v[1]),
        .ram_wren(wren_v[1]), .ram_data(rdat_v[1]), .ram_clken(clken_v[1]), .ram_q(qb2),
        .out_data(dat_v[1]), .out_valid(valid_v[1]), .out_ready(ready_v[1]), .out_last(last_v[1])
    );

    // RAM models: low clken zeroes q, as the wrapper does.
    always @(posedge clk) begin
        q_a <= clken_v[0] ? mem[addr_v[0]] : '0;
        qb0 <= clken_v[1] ? mem[addr_v[1]] : '0;
        qb1 <= qb0;
        qb2 <= qb1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   word_cnt[2], first_cyc[2], last_cyc[2], done_cnt[2], done_cyc[2];
    logic err_at_done[2];
    logic first_seen[2];
    int   spurious = 0;
    int   pin_bad = 0;
    int   max_occ = 0;
    logic [1:0] stall_v;
    logic [1:0][W-1:0] prev_dat;
    logic [1:0] prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            stall_v = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (stall_v[k]) begin
                    check($sformatf("hold_valid%0d", k), 64'(valid_v[k]), 64'(1));
                    check($sformatf("hold_data%0d", k), 64'(dat_v[k]), 64'(prev_dat[k]));
                    check($sformatf("hold_last%0d", k), 64'(last_v[k]), 64'(prev_last[k]));
                end
                if (valid_v[k] && ready_v[k]) begin
                    if (!first_seen[k]) begin
                        first_seen[k] = 1'b1;
                        first_cyc[k]  = cyc;
                    end
                    last_cyc[k] = cyc;
                    word_cnt[k]++;
                    if (exp_q.size() == 0) begin
                        spurious++;
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("data%0d", k), 64'(dat_v[k]), 64'(e.data));
                        check($sformatf("last%0d", k), 64'(last_v[k]), 64'(e.last));
                    end
                end
                stall_v[k]   = valid_v[k] && !ready_v[k];
                prev_dat[k]  = dat_v[k];
                prev_last[k] = last_v[k];
                if (done_v[k]) begin
                    done_cnt[k]++;
                    done_cyc[k]    = cyc;
                    err_at_done[k] = err_v[k];
                end
            end
            if (clken_v != 2'b11 || wren_v != 2'b00 || rdat_v != '0) pin_bad++;
            if (int'(u_dut_b.infl_q) + int'(u_dut_b.fifo_cnt) > max_occ)
                max_occ = int'(u_dut_b.infl_q) + int'(u_dut_b.fifo_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_window(input int base, input int num);
        exp_t e;
        for (int i = 0; i < num; i++) begin
            e.data = W'((base + i) % DEP);
            e.last = (i == num - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int k, input int base, input int num, output int sc);
        start_v[k] = 1'b1;
        base_v[k]  = AW'(base);
        num_v[k]   = (AW + 1)'(num);
        sc         = cyc;
        first_seen[k] = 1'b0;
        tick();
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int d0, input int budget, input bit toggle);
        int n = 0;
        while (done_cnt[k] == d0 && n < budget) begin
            if (toggle) ready_v[k] = ~ready_v[k];
            tick();
            n++;
        end
        check($sformatf("done_seen%0d", k), 64'(done_cnt[k] != d0), 64'(1));
    endtask

    // Common post-window checks: single done, err, word count, scoreboard drained.
    task automatic finish_window(input string nm, input int k, input int d0, input int w0,
                                 input int nwords, input logic exp_err);
        repeat (4) tick();
        check({nm, "_done_pulses"}, 64'(done_cnt[k] - d0), 64'(1));
        check({nm, "_err"}, 64'(err_at_done[k]), 64'(exp_err));
        check({nm, "_words"}, 64'(word_cnt[k] - w0), 64'(nwords));
        check({nm, "_queue_left"}, 64'(exp_q.size()), 64'(0));
        check({nm, "_spurious"}, 64'(spurious), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, sc2, d0, w0;
        logic [AW-1:0] addr0;
        for (int i = 0; i < DEP; i++) mem[i] = W'(i);
        for (int k = 0; k < 2; k++) begin
            word_cnt[k] = 0; first_cyc[k] = 0; last_cyc[k] = 0;
            done_cnt[k] = 0; done_cyc[k] = 0; err_at_done[k] = 1'b0; first_seen[k] = 1'b0;
        end
        stall_v = '0; prev_dat = '0; prev_last = '0;
        resetn = 1'b0; start_v = '0; base_v = '0; num_v = '0; ready_v = 2'b11;
        repeat (3) tick();

        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_busy%0d", k), 64'(busy_v[k]), 64'(0));
            check($sformatf("rst_done%0d", k), 64'(done_v[k]), 64'(0));
            check($sformatf("rst_err%0d", k), 64'(err_v[k]), 64'(0));
            check($sformatf("rst_valid%0d", k), 64'(valid_v[k]), 64'(0));
            check($sformatf("rst_last%0d", k), 64'(last_v[k]), 64'(0));
            check($sformatf("rst_addr%0d", k), 64'(addr_v[k]), 64'(0));
            check($sformatf("rst_data%0d", k), 64'(dat_v[k]), 64'(0));
            check($sformatf("rst_clken%0d", k), 64'(clken_v[k]), 64'(1));
        end
        resetn = 1'b1;
        tick();

        // Basic drain on the LATENCY=1 instance.
        d0 = done_cnt[0]; w0 = word_cnt[0];
        push_window(4, 8);
        pulse_start(0, 4, 8, sc);
        wait_done(0, d0, 100, 1'b0);
        check("basic_first_lat", 64'(first_cyc[0] - sc), 64'(LAT_A + 2));
        check("basic_burst_len", 64'(last_cyc[0] - first_cyc[0]), 64'(7));
        check("basic_done_after_last", 64'(done_cyc[0] - last_cyc[0]), 64'(1));
        finish_window("basic", 0, d0, w0, 8, 1'b0);

        // Backpressure on the LATENCY=3 instance with ready toggling every cycle.
        d0 = done_cnt[1]; w0 = word_cnt[1];
        push_window(0, 16);
        pulse_start(1, 0, 16, sc);
        wait_done(1, d0, 400, 1'b1);
        ready_v[1] = 1'b1;
        finish_window("bp", 1, d0, w0, 16, 1'b0);
        check("bp_credit_bound", 64'(max_occ <= FD_B), 64'(1));
        check("bp_ram_pins", 64'(pin_bad), 64'(0));

        // Zero-length window.
        d0 = done_cnt[0]; w0 = word_cnt[0]; addr0 = addr_v[0];
        pulse_start(0, 7, 0, sc);
        wait_done(0, d0, 6, 1'b0);
        check("zero_done_lat", 64'((done_cyc[0] - sc) <= 2), 64'(1));
        finish_window("zero", 0, d0, w0, 0, 1'b0);
        check("zero_addr_kept", 64'(addr_v[0]), 64'(addr0));

        // Window crossing the top of the RAM.
        d0 = done_cnt[0]; w0 = word_cnt[0];
`ifdef RAM_DRAIN_READER_WRAP_EN
        push_window(250, 10);
        pulse_start(0, 250, 10, sc);
        wait_done(0, d0, 100, 1'b0);
        finish_window("wrap", 0, d0, w0, 10, 1'b0);
`else
        pulse_start(0, 250, 10, sc);
        wait_done(0, d0, 10, 1'b0);
        finish_window("reject", 0, d0, w0, 0, 1'b1);
`endif

        // Reset with three reads in flight on the LATENCY=3 instance.
        ready_v[1] = 1'b0;
        d0 = done_cnt[1];
        pulse_start(1, 0, 16, sc);
        tick();
        tick();
        resetn = 1'b0;
        tick();
        check("mid_rst_busy", 64'(busy_v[1]), 64'(0));
        check("mid_rst_valid", 64'(valid_v[1]), 64'(0));
        check("mid_rst_no_done", 64'(done_cnt[1] - d0), 64'(0));
        resetn = 1'b1;
        ready_v[1] = 1'b1;
        tick();
        d0 = done_cnt[1]; w0 = word_cnt[1];
        push_window(0, 2);
        pulse_start(1, 0, 2, sc);
        wait_done(1, d0, 100, 1'b0);
        finish_window("post_rst", 1, d0, w0, 2, 1'b0);

        // Second start while busy is ignored.
        d0 = done_cnt[0]; w0 = word_cnt[0];
        push_window(20, 6);
        pulse_start(0, 20, 6, sc);
        tick();
        check("busy_during_issue", 64'(busy_v[0]), 64'(1));
        pulse_start(0, 100, 3, sc2);
        wait_done(0, d0, 100, 1'b0);
        finish_window("restart", 0, d0, w0, 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
